can_acceptance_filter: RTL and testbench

- Sits directly downstream of the parameter registry, which holds the mask, code and SJW settings of the CAN controller.
- Captures the 11-bit standard identifier of each received frame, one bit at a time, from the bit-destuffed receive stream.
- Compares the captured identifier against the registry's code_param/mask_param and issues a single accept or reject decision per frame.
- Keeps a saturating count of accepted frames for the host.

---
 rtl/can_acceptance_filter_if.sv | 37 +++
 rtl/can_acceptance_filter.sv | 133 +++++++++++++
 tb/tb_can_acceptance_filter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_acceptance_filter_if.sv
//------------------------------------------------------------------------------
// Module      : can_acceptance_filter_if
// Description : Bus bundle between the CAN receive front end/registry and the
//               acceptance filter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface can_acceptance_filter_if #(
    parameter int ID_W  = 11,
    parameter int CNT_W = 8
);
    logic [ID_W-1:0]  mask_param;
    logic [ID_W-1:0]  code_param;
    logic             sof;
    logic             bit_valid;
    logic             rx_bit;
    logic             frame_end;
    logic             frame_abort;
    logic [ID_W-1:0]  id_out;
    logic             id_accept;
    logic             id_reject;
    logic             busy;
    logic [CNT_W-1:0] accept_cnt;

    modport slave (
        input  mask_param, code_param, sof, bit_valid, rx_bit, frame_end, frame_abort,
        output id_out, id_accept, id_reject, busy, accept_cnt
    );

    modport master (
        output mask_param, code_param, sof, bit_valid, rx_bit, frame_end, frame_abort,
        input  id_out, id_accept, id_reject, busy, accept_cnt
    );
endinterface

`default_nettype wire

// File: rtl/can_acceptance_filter.sv
//------------------------------------------------------------------------------
// Module      : can_acceptance_filter
// Description : Captures the 11-bit CAN standard identifier from the destuffed
//               bit stream and issues one accept/reject decision per frame.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module can_acceptance_filter #(
    parameter int ID_W  = 11,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    can_acceptance_filter_if.slave  bus
);

    localparam int                    c_BCNT_W   = $clog2(ID_W + 1);
    localparam logic [c_BCNT_W-1:0]   c_LAST_BIT = c_BCNT_W'(ID_W - 1);
    localparam logic [CNT_W-1:0]      c_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFT_ID = 2'd1,
        S_DECIDE   = 2'd2,
        S_WAIT_EOF = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_sof_load;
    logic                w_shift_en;
    logic                w_decide;
    logic                w_match;
    logic [ID_W-1:0]     w_shift_next;

    logic [ID_W-1:0]     r_shift;
    logic [c_BCNT_W-1:0] r_bit_cnt;
    logic [ID_W-1:0]     r_mask;
    logic [ID_W-1:0]     r_code;
    logic [ID_W-1:0]     r_id_out;
    logic                r_accept;
    logic                r_reject;
    logic [CNT_W-1:0]    r_accept_cnt;

    // The decision is computed on the edge that samples the last bit, so the
    // pulse and id_out are both registered and visible during DECIDE.
    assign w_shift_next = {r_shift[ID_W-2:0], bus.rx_bit};
    assign w_match      = ((w_shift_next ^ r_code) & r_mask) == '0;

    always_comb begin
        w_state_next = r_state;
        w_sof_load   = 1'b0;
        w_shift_en   = 1'b0;
        w_decide     = 1'b0;
        if (bus.frame_abort) begin
            w_state_next = S_IDLE;
        end else if (bus.sof) begin
            w_state_next = S_SHIFT_ID;
            w_sof_load   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_IDLE;
                end
                S_SHIFT_ID: begin
                    if (bus.frame_end) begin
                        w_state_next = S_IDLE;
                    end else if (bus.bit_valid) begin
                        w_shift_en = 1'b1;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            w_state_next = S_DECIDE;
                            w_decide     = 1'b1;
                        end
                    end
                end
                S_DECIDE: begin
                    w_state_next = S_WAIT_EOF;
                end
                S_WAIT_EOF: begin
                    if (bus.frame_end) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_mask       <= '0;
            r_code       <= '0;
            r_id_out     <= '0;
            r_accept     <= 1'b0;
            r_reject     <= 1'b0;
            r_accept_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_accept <= w_decide & w_match;
            r_reject <= w_decide & ~w_match;
            if (w_sof_load) begin
                r_mask    <= bus.mask_param;
                r_code    <= bus.code_param;
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_shift_en) begin
                r_shift   <= w_shift_next;
                r_bit_cnt <= r_bit_cnt + c_BCNT_W'(1);
            end
            if (w_decide) begin
                r_id_out <= w_shift_next;
                if (w_match && (r_accept_cnt != c_CNT_MAX)) begin
                    r_accept_cnt <= r_accept_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.id_out     = r_id_out;
    assign bus.id_accept  = r_accept;
    assign bus.id_reject  = r_reject;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.accept_cnt = r_accept_cnt;

endmodule

`default_nettype wire

// File: tb/tb_can_acceptance_filter.sv
//------------------------------------------------------------------------------
// Module      : tb_can_acceptance_filter
// Description : Directed plus randomized self-checking bench for the CAN
//               acceptance filter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_can_acceptance_filter;

    localparam int c_ID_W  = 11;
    localparam int c_CNT_W = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n_acc;
    int   n_rej;
    int   exp_cnt;
    logic [c_ID_W-1:0] exp_id;

    can_acceptance_filter_if #(.ID_W(c_ID_W), .CNT_W(c_CNT_W)) bus ();

    can_acceptance_filter #(.ID_W(c_ID_W), .CNT_W(c_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.id_accept === 1'b1) n_acc++;
        if (bus.id_reject === 1'b1) n_rej++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Filter rule: every bit selected by the mask must equal the code bit.
    function automatic bit model_match(input logic [c_ID_W-1:0] id,
                                       input logic [c_ID_W-1:0] m,
                                       input logic [c_ID_W-1:0] c);
        for (int i = 0; i < c_ID_W; i++)
            if (m[i] && (id[i] != c[i])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_decide(input bit hit, input logic [c_ID_W-1:0] id);
        exp_id = id;
        if (hit && exp_cnt < 255) exp_cnt++;
    endtask

    task automatic send_bits(input logic [c_ID_W-1:0] id, input int nbits, input bit gaps);
        for (int i = c_ID_W - 1; i >= c_ID_W - nbits; i--) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            bus.bit_valid = 1'b1;
            bus.rx_bit    = id[i];
            tick();
            bus.bit_valid = 1'b0;
            bus.rx_bit    = 1'b0;
        end
    endtask

    // Full frame: sof, 11 id bits, decision check, frame_end.
    task automatic frame(input logic [c_ID_W-1:0] id, input bit change_code,
                         input logic [c_ID_W-1:0] new_code, input bit gaps);
        logic [c_ID_W-1:0] m, c;
        bit hit;
        int a0, r0;
        m  = bus.mask_param;
        c  = bus.code_param;
        a0 = n_acc;
        r0 = n_rej;
        bus.sof = 1'b1;
        tick();
        bus.sof = 1'b0;
        if (change_code) bus.code_param = new_code;
        chk("busy_after_sof", bus.busy, 1);
        send_bits(id, c_ID_W, gaps);
        hit = model_match(id, m, c);
        model_decide(hit, id);
        chk("accept_pulse", bus.id_accept, hit);
        chk("reject_pulse", bus.id_reject, !hit);
        chk("id_out", bus.id_out, exp_id);
        chk("accept_cnt", bus.accept_cnt, exp_cnt);
        tick();
        chk("accept_next", bus.id_accept, 0);
        chk("reject_next", bus.id_reject, 0);
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        chk("busy_after_eof", bus.busy, 0);
        chk("acc_pulses", n_acc - a0, hit);
        chk("rej_pulses", n_rej - r0, !hit);
    endtask

    initial begin
        int a0, r0;
        logic [c_ID_W-1:0] rid, m, c;
        checks  = 0;
        errors  = 0;
        n_acc   = 0;
        n_rej   = 0;
        exp_cnt = 0;
        exp_id  = '0;
        reset   = 1'b0;
        bus.mask_param  = '0;
        bus.code_param  = '0;
        bus.sof         = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.rx_bit      = 1'b0;
        bus.frame_end   = 1'b0;
        bus.frame_abort = 1'b0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_id_out", bus.id_out, 0);
        chk("rst_cnt", bus.accept_cnt, 0);
        chk("rst_acc", bus.id_accept, 0);
        chk("rst_rej", bus.id_reject, 0);
        #3 reset = 1'b1;
        tick();

        // Exact match
        bus.mask_param = 11'h7FF;
        bus.code_param = 11'h2A5;
        frame(11'h2A5, 1'b0, '0, 1'b0);

        // Don't-care bits, then reject
        bus.mask_param = 11'h700;
        bus.code_param = 11'h300;
        frame(11'h3FF, 1'b0, '0, 1'b0);
        frame(11'h4FF, 1'b0, '0, 1'b0);

        // Registry changes after sof are isolated
        bus.mask_param = 11'h7FF;
        bus.code_param = 11'h123;
        frame(11'h123, 1'b1, 11'h456, 1'b1);
        chk("iso_cnt", bus.accept_cnt, exp_cnt);

        // Abort after 6 bits
        a0 = n_acc;
        r0 = n_rej;
        bus.code_param = 11'h456;
        bus.sof = 1'b1;
        tick();
        bus.sof = 1'b0;
        send_bits(11'h456, 6, 1'b0);
        bus.frame_abort = 1'b1;
        tick();
        bus.frame_abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        // Bits after abort are ignored in IDLE
        send_bits(11'h456, 5, 1'b0);
        repeat (2) tick();
        chk("abort_busy_idle", bus.busy, 0);
        chk("abort_id_out", bus.id_out, exp_id);
        chk("abort_cnt", bus.accept_cnt, exp_cnt);

        // Truncated frame after 9 bits
        bus.sof = 1'b1;
        tick();
        bus.sof = 1'b0;
        send_bits(11'h456, 9, 1'b0);
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        chk("trunc_busy", bus.busy, 0);
        send_bits(11'h456, 2, 1'b0);
        repeat (2) tick();
        chk("trunc_acc_pulses", n_acc - a0, 0);
        chk("trunc_rej_pulses", n_rej - r0, 0);
        chk("trunc_id_out", bus.id_out, exp_id);
        frame(11'h456, 1'b0, '0, 1'b0);

        // Restart: sof coincident with bit_valid drops that bit
        a0 = n_acc;
        bus.mask_param = 11'h7FF;
        bus.code_param = 11'h0F0;
        bus.sof = 1'b1;
        tick();
        bus.sof = 1'b0;
        send_bits(11'h7FF, 5, 1'b0);
        bus.code_param = 11'h555;
        bus.sof        = 1'b1;
        bus.bit_valid  = 1'b1;
        bus.rx_bit     = 1'b1;
        tick();
        bus.sof       = 1'b0;
        bus.bit_valid = 1'b0;
        send_bits(11'h555, c_ID_W, 1'b0);
        model_decide(model_match(11'h555, 11'h7FF, 11'h555), 11'h555);
        chk("restart_acc", bus.id_accept, 1);
        chk("restart_id_out", bus.id_out, exp_id);
        chk("restart_cnt", bus.accept_cnt, exp_cnt);
        tick();
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
        chk("restart_acc_pulses", n_acc - a0, 1);

        // Randomized frames against the model
        for (int k = 0; k < 30; k++) begin
            m = c_ID_W'($urandom);
            c = c_ID_W'($urandom);
            bus.mask_param = m;
            bus.code_param = c;
            rid = ($urandom_range(0, 1) == 1) ? (c ^ c_ID_W'($urandom & ~32'(m)))
                                               : c_ID_W'($urandom);
            frame(rid, 1'b0, '0, 1'b1);
        end

        // Async reset mid SHIFT_ID
        bus.mask_param = 11'h7FF;
        bus.code_param = 11'h1A3;
        bus.sof = 1'b1;
        tick();
        bus.sof = 1'b0;
        send_bits(11'h1A3, 4, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_id_out", bus.id_out, 0);
        chk("arst_cnt", bus.accept_cnt, 0);
        chk("arst_acc", bus.id_accept, 0);
        chk("arst_rej", bus.id_reject, 0);
        exp_cnt = 0;
        exp_id  = '0;
        tick();
        #3 reset = 1'b1;
        a0 = n_acc;
        r0 = n_rej;
        send_bits(11'h1A3, c_ID_W, 1'b0);
        repeat (2) tick();
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_pulses", (n_acc - a0) + (n_rej - r0), 0);

        // Saturation: 260 accepted frames
        for (int k = 0; k < 260; k++) begin
            m = c_ID_W'($urandom);
            c = c_ID_W'($urandom);
            bus.mask_param = m;
            bus.code_param = c;
            frame(c ^ c_ID_W'($urandom & ~32'(m)), 1'b0, '0, 1'b0);
        end
        chk("sat_cnt", bus.accept_cnt, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
